// File: rtl/conv2d_frame_streamer_pkg.sv
// Shared defaults and state encoding for the conv2d frame streamer.
package conv2d_frame_streamer_pkg;

    localparam int DEF_IMG_W   = 5;
    localparam int DEF_IMG_H   = 5;
    localparam int DEF_PIX_W   = 8;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_TIMEOUT = 50;
    localparam int N_PIX       = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } stream_state_t;

endpackage

// File: rtl/conv2d_frame_streamer_if.sv
// Pixel-stream link between the frame streamer (master) and conv2d (slave).
interface conv2d_frame_streamer_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
);
    logic             conv_start;
    logic [PIX_W-1:0] conv_in_data;
    logic             conv_done;
    logic [OUT_W-1:0] conv_out_data;

    modport master (
        output conv_start,
        output conv_in_data,
        input  conv_done,
        input  conv_out_data
    );

    modport slave (
        input  conv_start,
        input  conv_in_data,
        output conv_done,
        output conv_out_data
    );
endinterface

// File: rtl/conv2d_frame_streamer_ram.sv
// Frame buffer: one host write port, one combinational read port with
// write-first bypass so a same-cycle write is visible on the read data.
module conv2d_frame_streamer_ram #(
    parameter int N_PIX  = 25,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PIX_W-1:0]  rd_data_o
);

    logic [PIX_W-1:0] mem_q [N_PIX];
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign wr_ok_s = wr_en_i && (int'(wr_addr_i) < N_PIX);
    assign rd_ok_s = (int'(rd_addr_i) < N_PIX);

    // Pixel storage; deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read mux with bypass of the in-flight write.
    always_comb begin
        rd_data_o = '0;
        if (wr_ok_s && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end else if (rd_ok_s) begin
            rd_data_o = mem_q[rd_addr_i];
        end else begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/conv2d_frame_streamer.sv
// Frame streamer: buffers a host-written frame, streams it raster-order into
// conv2d, then waits a bounded time for conv2d done and captures its result.
module conv2d_frame_streamer
    import conv2d_frame_streamer_pkg::*;
#(
    parameter int  IMG_W   = DEF_IMG_W,
    parameter int  IMG_H   = DEF_IMG_H,
    parameter int  PIX_W   = DEF_PIX_W,
    parameter int  OUT_W   = DEF_OUT_W,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int FRAME_PIX = IMG_W * IMG_H,
    localparam int ADDR_W    = $clog2(FRAME_PIX),
    localparam int TMR_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [PIX_W-1:0]     wr_data_i,
    input  logic                 go_i,
    output logic                 busy_o,
    conv2d_frame_streamer_if.master conv_if,
    output logic [OUT_W-1:0]     result_o,
    output logic                 result_valid_o,
    output logic                 timeout_err_o
);

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              busy_q, busy_d;
    logic              conv_start_q, conv_start_d;
    logic [PIX_W-1:0]  conv_in_data_q, conv_in_data_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              timeout_err_q, timeout_err_d;

    logic              ram_wr_en_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [PIX_W-1:0]  rd_data_s;
    logic              last_beat_s;
    logic              timer_hit_s;

    // beat_q is the index currently on conv_in_data; the RAM is read one ahead.
    assign last_beat_s = (beat_q == ADDR_W'(FRAME_PIX - 1));
    assign timer_hit_s = (timer_q == TMR_W'(TIMEOUT));
    assign rd_addr_s   = ((state_q == S_STREAM) && !last_beat_s) ? (beat_q + ADDR_W'(1)) : '0;
    assign ram_wr_en_s = wr_en_i && (state_q == S_IDLE);

    conv2d_frame_streamer_ram #(
        .N_PIX  (FRAME_PIX),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en_s),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            timer_q        <= '0;
            busy_q         <= 1'b0;
            conv_start_q   <= 1'b0;
            conv_in_data_q <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            conv_start_q   <= conv_start_d;
            conv_in_data_q <= conv_in_data_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (last_beat_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT: begin
                if (conv_if.conv_done || timer_hit_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        beat_d         = beat_q;
        timer_d        = timer_q;
        busy_d         = (state_d != S_IDLE);
        conv_start_d   = 1'b0;
        conv_in_data_d = '0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                beat_d  = '0;
                timer_d = '0;
                if (go_i) begin
                    conv_start_d   = 1'b1;
                    conv_in_data_d = rd_data_s;
                end else begin
                    conv_start_d   = 1'b0;
                end
            end
            S_STREAM: begin
                if (last_beat_s) begin
                    beat_d  = '0;
                    timer_d = '0;
                end else begin
                    beat_d         = beat_q + ADDR_W'(1);
                    conv_start_d   = 1'b1;
                    conv_in_data_d = rd_data_s;
                end
            end
            S_WAIT: begin
                // A done arriving on the final timer cycle still wins over the error.
                if (conv_if.conv_done) begin
                    result_d       = conv_if.conv_out_data;
                    result_valid_d = 1'b1;
                    timer_d        = '0;
                end else if (timer_hit_s) begin
                    timeout_err_d  = 1'b1;
                    timer_d        = '0;
                end else begin
                    timer_d        = timer_q + TMR_W'(1);
                end
            end
            default: begin
                beat_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    assign busy_o               = busy_q;
    assign conv_if.conv_start   = conv_start_q;
    assign conv_if.conv_in_data = conv_in_data_q;
    assign result_o             = result_q;
    assign result_valid_o       = result_valid_q;
    assign timeout_err_o        = timeout_err_q;

endmodule

// File: tb/tb_conv2d_frame_streamer.sv
// Scoreboard bench for conv2d_frame_streamer with a small conv2d stand-in.
module tb_conv2d_frame_streamer;
    import conv2d_frame_streamer_pkg::*;

    localparam int N      = DEF_IMG_W * DEF_IMG_H;
    localparam int ADDR_W = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = 8'd0;
    logic              go = 1'b0;
    logic              busy;
    logic [15:0]       result;
    logic              result_valid;
    logic              timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  shadow [N];
    logic [7:0]  cap [N];
    int          cap_cnt = 0;
    logic [7:0]  exp_pix [$];
    logic [15:0] exp_res [$];

    conv2d_frame_streamer_if #(.PIX_W(DEF_PIX_W), .OUT_W(DEF_OUT_W)) cif ();

    conv2d_frame_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .go_i           (go),
        .busy_o         (busy),
        .conv_if        (cif.master),
        .result_o       (result),
        .result_valid_o (result_valid),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // conv2d stand-in: sum of the centre 3x3 window of the frame.
    function automatic logic [15:0] win_sum(input logic [7:0] px [N]);
        logic [15:0] s;
        s = 16'd0;
        for (int r = DEF_IMG_H / 2 - 1; r <= DEF_IMG_H / 2 + 1; r++)
            for (int c = DEF_IMG_W / 2 - 1; c <= DEF_IMG_W / 2 + 1; c++)
                s = s + 16'(px[r * DEF_IMG_W + c]);
        return s;
    endfunction

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_pix.push_back(shadow[i]);
    endtask

    task automatic start_frame();
        cap_cnt = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // act: 0 none, 1 early conv_done, 2 host write to addr 4; applied at beat at_beat.
    task automatic stream_phase(input int act, input int at_beat, output int beats);
        beats = 0;
        while (cif.conv_start && beats < N + 5) begin
            if (beats == at_beat && act == 1) begin
                cif.conv_done = 1'b1; cif.conv_out_data = 16'hDEAD;
            end else if (beats == at_beat && act == 2) begin
                wr_en = 1'b1; wr_addr = ADDR_W'(4); wr_data = 8'hFF;
            end
            tick();
            cif.conv_done = 1'b0;
            wr_en = 1'b0;
            beats++;
        end
    endtask

    task automatic wait_phase(input int done_at, input logic [15:0] val);
        for (int i = 0; i < done_at; i++) tick();
        cif.conv_done = 1'b1;
        cif.conv_out_data = val;
        tick();
        cif.conv_done = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cif.conv_start) begin
                    if (exp_pix.size() == 0) check_eq("extra_beat", 32'd1, 32'd0);
                    else check_eq("beat", 32'(cif.conv_in_data), 32'(exp_pix.pop_front()));
                    if (cap_cnt < N) cap[cap_cnt] = cif.conv_in_data;
                    cap_cnt++;
                end
                if (result_valid) begin
                    if (exp_res.size() == 0) check_eq("extra_result", 32'd1, 32'd0);
                    else check_eq("result", 32'(result), 32'(exp_res.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int t;
        int vcnt;
        int idle;
        int fcnt;
        logic prev_start;
        logic [15:0] v;

        cif.conv_done = 1'b0;
        cif.conv_out_data = 16'h0000;
        tick(); tick(); tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(cif.conv_start), 32'd0);
        check_eq("rst_data", 32'(cif.conv_in_data), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 8'(i + 1);
            shadow[i] = 8'(i + 1);
            tick();
        end
        wr_en = 1'b0;

        // Reset during beat 7 of a stream.
        push_frame();
        start_frame();
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_start", 32'(cif.conv_start), 32'd0);
        check_eq("midrst_data", 32'(cif.conv_in_data), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(result_valid), 32'd0);
        exp_pix.delete();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Full frame with conv2d model result.
        push_frame();
        start_frame();
        stream_phase(0, -1, beats);
        check_eq("beats_full", 32'(beats), 32'(N));
        exp_res.push_back(win_sum(shadow));
        wait_phase(2, win_sum(cap));
        tick();
        check_eq("valid_pulse", 32'(result_valid), 32'd0);
        check_eq("result_hold", 32'(result), 32'(win_sum(shadow)));

        // Timeout: WAIT cycles with timer 0..TIMEOUT, error visible on the next one.
        push_frame();
        start_frame();
        stream_phase(0, -1, beats);
        check_eq("beats_to", 32'(beats), 32'(N));
        t = 0;
        for (int i = 1; i <= DEF_TIMEOUT + 10; i++) begin
            tick();
            if (timeout_err) begin t = i; break; end
        end
        check_eq("timeout_cycle", 32'(t), 32'(DEF_TIMEOUT + 1));
        check_eq("timeout_busy", 32'(busy), 32'd0);
        check_eq("timeout_result", 32'(result), 32'(win_sum(shadow)));
        tick();
        check_eq("timeout_pulse", 32'(timeout_err), 32'd0);

        // Done on the last allowed WAIT cycle wins over the error.
        push_frame();
        start_frame();
        stream_phase(0, -1, beats);
        exp_res.push_back(16'h0BEE);
        wait_phase(DEF_TIMEOUT, 16'h0BEE);
        check_eq("edge_no_err", 32'(timeout_err), 32'd0);
        check_eq("edge_valid", 32'(result_valid), 32'd1);

        // Early done during streaming is ignored.
        push_frame();
        start_frame();
        stream_phase(1, 10, beats);
        check_eq("beats_early", 32'(beats), 32'(N));
        exp_res.push_back(16'h1234);
        wait_phase(3, 16'h1234);
        check_eq("early_result", 32'(result), 32'h1234);

        // Host write while busy is dropped.
        push_frame();
        start_frame();
        stream_phase(2, 2, beats);
        exp_res.push_back(16'h0055);
        wait_phase(0, 16'h0055);
        wr_en = 1'b1; wr_addr = ADDR_W'(25); wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;

        // Write to index 0 together with go is seen by beat 0.
        shadow[0] = 8'h77;
        push_frame();
        cap_cnt = 0;
        wr_en = 1'b1; wr_addr = ADDR_W'(0); wr_data = 8'h77; go = 1'b1;
        tick();
        wr_en = 1'b0; go = 1'b0;
        stream_phase(0, -1, beats);
        check_eq("beats_wf", 32'(beats), 32'(N));
        exp_res.push_back(16'h0066);
        wait_phase(1, 16'h0066);
        tick();

        // go held high: three back-to-back frames, one IDLE cycle between.
        for (int f = 0; f < 3; f++) begin
            push_frame();
            exp_res.push_back(16'h0100 + 16'(f));
        end
        vcnt = 0; idle = 0; fcnt = 0; prev_start = 1'b0;
        go = 1'b1;
        for (int i = 0; i < 400 && vcnt < 3; i++) begin
            tick();
            cif.conv_done = 1'b0;
            if (result_valid) vcnt++;
            if (!busy && vcnt > 0 && vcnt < 3) idle++;
            if (vcnt == 3) go = 1'b0;
            if (prev_start && !cif.conv_start) begin
                v = 16'h0100 + 16'(fcnt);
                cif.conv_done = 1'b1;
                cif.conv_out_data = v;
                fcnt++;
            end
            prev_start = cif.conv_start;
        end
        go = 1'b0;
        cif.conv_done = 1'b0;
        check_eq("b2b_valids", 32'(vcnt), 32'd3);
        check_eq("b2b_idle", 32'(idle), 32'd2);
        tick();
        check_eq("b2b_stop", 32'(busy), 32'd0);

        tick();
        check_eq("pix_left", 32'(exp_pix.size()), 32'd0);
        check_eq("res_left", 32'(exp_res.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
